// File: rtl/fpga_ddr3_example_if0_dmaster_b2p.sv
// Bytes-to-packets decoder for the DDR3 debug master byte path.
// It strips 7A/7B/7C/7D control characters from an 8-bit valid/ready stream
// and emits a packet stream with SOP/EOP/channel sideband.
// Ports: clk, reset_n (sync, active low); in_valid/in_data/in_ready (byte in);
// out_valid/out_data/out_startofpacket/out_endofpacket/out_channel/out_ready
// (packet out); overflow_err (sticky: a byte was presented while in_ready low).
// Optional macro FPGA_DDR3_DMASTER_B2P_CHANNEL_EN enables channel decode;
// without it out_channel is tied to 0 and channel value bytes are discarded.
module fpga_ddr3_example_if0_dmaster_b2p #(
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [CHANNEL_WIDTH-1:0] out_channel,
    input  logic                     out_ready,
    output logic                     overflow_err
);

    localparam logic [7:0] SOP_C  = 8'h7A;
    localparam logic [7:0] EOP_C  = 8'h7B;
    localparam logic [7:0] CHAN_C = 8'h7C;
    localparam logic [7:0] ESC_C  = 8'h7D;

    logic       esc_q;
    logic       sop_q;
    logic       eop_q;
    logic       chan_q;
    logic       accept;
    logic       ctrl;
    logic       is_esc;
    logic       is_sop;
    logic       is_eop;
    logic       is_chan;
    logic       is_val;
    logic       is_data;
    logic [7:0] val;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Classify the accepted byte; the cases are mutually exclusive.
    always_comb begin
        is_esc  = 1'b0;
        is_sop  = 1'b0;
        is_eop  = 1'b0;
        is_chan = 1'b0;
        is_val  = 1'b0;
        is_data = 1'b0;
        val     = esc_q ? (in_data ^ 8'h20) : in_data;
        // Unescaped controls win even while a channel value is awaited.
        ctrl    = !esc_q && (in_data >= SOP_C) && (in_data <= ESC_C);
        if (accept) begin
            unique case (1'b1)
                ctrl && (in_data == ESC_C):  is_esc  = 1'b1;
                ctrl && (in_data == SOP_C):  is_sop  = 1'b1;
                ctrl && (in_data == EOP_C):  is_eop  = 1'b1;
                ctrl && (in_data == CHAN_C): is_chan = 1'b1;
                !ctrl && chan_q:             is_val  = 1'b1;
                default:                     is_data = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            esc_q             <= 1'b0;
            sop_q             <= 1'b0;
            eop_q             <= 1'b0;
            chan_q            <= 1'b0;
            out_valid         <= 1'b0;
            out_data          <= 8'h00;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            overflow_err      <= 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                overflow_err <= 1'b1;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (is_esc)  esc_q  <= 1'b1;
            if (is_sop)  sop_q  <= 1'b1;
            if (is_eop)  eop_q  <= 1'b1;
            if (is_chan) chan_q <= 1'b1;
            if (is_val) begin
                chan_q <= 1'b0;
                esc_q  <= 1'b0;
            end
            if (is_data) begin
                out_valid         <= 1'b1;
                out_data          <= val;
                out_startofpacket <= sop_q;
                out_endofpacket   <= eop_q;
                sop_q             <= 1'b0;
                eop_q             <= 1'b0;
                esc_q             <= 1'b0;
            end
        end
    end

`ifdef FPGA_DDR3_DMASTER_B2P_CHANNEL_EN
    logic [CHANNEL_WIDTH-1:0] channel_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            channel_reg <= '0;
            out_channel <= '0;
        end else begin
            if (is_val) begin
                channel_reg <= val[CHANNEL_WIDTH-1:0];
            end
            if (is_data) begin
                out_channel <= channel_reg;
            end
        end
    end
`else
    assign out_channel = '0;
`endif

endmodule
